// File: rtl/backprop_delta_unit.sv
// Backprop delta stage: delta = e * sigmoid'(z), two-stage valid/ready pipeline with per-vector counter.
// Optional round-half-up of the product is built when DELTA_ROUND_EN is defined (floor shift otherwise).

module sigmoid_deriv #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic [DATA_WIDTH-1:0] z_i,
  output logic [DATA_WIDTH-1:0] deriv_o
);
  localparam int RANGE = 8 << FRAC_BITS;

  logic [DATA_WIDTH:0] abs_z;
  logic [3:0]          idx;
  logic [6:0]          lut8;

  // Table holds round(256*s'(x)) at 0.5 steps over |z| in [0,8); symmetric in z.
  always_comb begin
    abs_z = z_i[DATA_WIDTH-1] ? -{z_i[DATA_WIDTH-1], z_i} : {1'b0, z_i};
    idx   = 4'(abs_z >> (FRAC_BITS-1));
    case (idx)
      4'd0:    lut8 = 7'd64;
      4'd1:    lut8 = 7'd60;
      4'd2:    lut8 = 7'd50;
      4'd3:    lut8 = 7'd38;
      4'd4:    lut8 = 7'd27;
      4'd5:    lut8 = 7'd18;
      4'd6:    lut8 = 7'd12;
      4'd7:    lut8 = 7'd7;
      4'd8:    lut8 = 7'd5;
      4'd9:    lut8 = 7'd3;
      4'd10:   lut8 = 7'd2;
      4'd11:   lut8 = 7'd1;
      4'd12:   lut8 = 7'd1;
      default: lut8 = 7'd0;
    endcase
    if (abs_z >= (DATA_WIDTH+1)'(RANGE)) lut8 = 7'd0;
  end

  generate
    if (FRAC_BITS >= 8) begin : g_scale_up
      assign deriv_o = DATA_WIDTH'(lut8) << (FRAC_BITS-8);
    end else begin : g_scale_dn
      assign deriv_o = DATA_WIDTH'(lut8) >> (8-FRAC_BITS);
    end
  endgenerate
endmodule

module backprop_delta_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] z_i,
  input  logic [DATA_WIDTH-1:0] e_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] delta_o,
  output logic                  out_last_o,
  output logic [CNT_WIDTH-1:0]  cnt_o
);
  localparam int PW = 2*DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] deriv;
  logic                  s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [DATA_WIDTH-1:0] s1_e_q, s1_e_d, s1_deriv_q, s1_deriv_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] delta_q, delta_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  s2_adv, in_xfer, out_xfer;
  logic signed [PW-1:0]  prod, prod_adj;
  logic [DATA_WIDTH-1:0] delta_calc;

  sigmoid_deriv #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_deriv (
    .z_i    (z_i),
    .deriv_o(deriv)
  );

  assign s2_adv     = !out_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s2_adv;
  assign in_xfer    = in_valid_i && in_ready_o;
  assign out_xfer   = out_valid_q && out_ready_i;

`ifdef DELTA_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC_BITS-1);
`endif

  // deriv is unsigned and <= 0.25, so the shifted product always fits DATA_WIDTH.
  always_comb begin
    prod = $signed({{(DATA_WIDTH+1){s1_e_q[DATA_WIDTH-1]}}, s1_e_q})
         * $signed({{(DATA_WIDTH+1){1'b0}}, s1_deriv_q});
`ifdef DELTA_ROUND_EN
    prod_adj = prod + HALF;
`else
    prod_adj = prod;
`endif
    delta_calc = DATA_WIDTH'(prod_adj >>> FRAC_BITS);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_e_d      = s1_e_q;
    s1_deriv_d  = s1_deriv_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    delta_d     = delta_q;
    cnt_d       = cnt_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_last_d  = in_last_i;
      s1_e_d     = e_i;
      s1_deriv_d = deriv;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        delta_d    = delta_calc;
        out_last_d = s1_last_q;
      end
    end
    if (out_xfer) cnt_d = out_last_q ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_e_q      <= '0;
      s1_deriv_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      delta_q     <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_e_q      <= s1_e_d;
      s1_deriv_q  <= s1_deriv_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      delta_q     <= delta_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign delta_o     = delta_q;
  assign cnt_o       = cnt_q;
endmodule

// File: tb/tb_backprop_delta_unit.sv
// Directed self-checking bench for backprop_delta_unit (both DELTA_ROUND_EN builds).
module tb_backprop_delta_unit;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i, in_ready_o, in_last_i;
  logic [15:0] z_i, e_i;
  logic        out_valid_o, out_ready_i, out_last_o;
  logic [15:0] delta_o;
  logic [7:0]  cnt_o;

  int checks = 0;
  int errors = 0;

  backprop_delta_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .z_i(z_i), .e_i(e_i), .in_last_i(in_last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .delta_o(delta_o), .out_last_o(out_last_o), .cnt_o(cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Called 1ns after a rising edge with the pipeline empty; leaves it drained.
  task automatic send_one(input logic [15:0] z, input logic [15:0] e, input logic last,
                          output logic v1, output logic v2, output logic l2,
                          output logic [15:0] d2, output logic [7:0] c2);
    z_i = z; e_i = e; in_last_i = last; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    v1 = out_valid_o;
    @(posedge clk_i); #1;
    v2 = out_valid_o; l2 = out_last_o; d2 = delta_o; c2 = cnt_o;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    z_i = '0; e_i = '0; in_last_i = 1'b0;
    #3;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got=%b exp=0", out_valid_o); end
    checks++; if (delta_o !== 16'h0) begin errors++; $display("FAIL rst_delta: got=%h exp=0000", delta_o); end
    checks++; if (cnt_o !== 8'h0 || out_last_o !== 1'b0) begin errors++; $display("FAIL rst_cnt_last: cnt=%h last=%b exp=00/0", cnt_o, out_last_o); end
    #9 rst_i = 1'b0;
    @(posedge clk_i); #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got=%b exp=1", in_ready_o); end
  endtask

  task automatic test_basic;
    logic v1, v2, l2; logic [15:0] d; logic [7:0] c;
    send_one(16'h0000, 16'h0100, 1'b1, v1, v2, l2, d, c);
    checks++; if (v1 !== 1'b0 || v2 !== 1'b1) begin errors++; $display("FAIL latency: v1=%b v2=%b exp=0/1", v1, v2); end
    checks++; if (d !== 16'h0040) begin errors++; $display("FAIL basic_pos: got=%h exp=0040", d); end
    checks++; if (l2 !== 1'b1) begin errors++; $display("FAIL basic_last: got=%b exp=1", l2); end
    send_one(16'h0000, 16'hFF00, 1'b1, v1, v2, l2, d, c);
    checks++; if (d !== 16'hFFC0) begin errors++; $display("FAIL basic_neg: got=%h exp=ffc0", d); end
  endtask

  task automatic test_lut_range;
    logic v1, v2, l2; logic [15:0] d; logic [7:0] c;
    send_one(16'h0800, 16'h7FFF, 1'b1, v1, v2, l2, d, c);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL range_pos: got=%h exp=0000", d); end
    send_one(16'hF700, 16'h0100, 1'b1, v1, v2, l2, d, c);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL range_neg: got=%h exp=0000", d); end
    send_one(16'h0100, 16'h0100, 1'b1, v1, v2, l2, d, c);
    checks++; if (d !== 16'h0032) begin errors++; $display("FAIL lut_z1: got=%h exp=0032", d); end
    send_one(16'hFF00, 16'h0100, 1'b1, v1, v2, l2, d, c);
    checks++; if (d !== 16'h0032) begin errors++; $display("FAIL lut_zm1: got=%h exp=0032", d); end
    send_one(16'h0200, 16'h0100, 1'b1, v1, v2, l2, d, c);
    checks++; if (d !== 16'h001B) begin errors++; $display("FAIL lut_z2: got=%h exp=001b", d); end
  endtask

  task automatic test_rounding;
    logic v1, v2, l2; logic [15:0] d, exp_p, exp_n; logic [7:0] c;
`ifdef DELTA_ROUND_EN
    exp_p = 16'h0001; exp_n = 16'h0000;
`else
    exp_p = 16'h0000; exp_n = 16'hFFFF;
`endif
    send_one(16'h0000, 16'h0002, 1'b1, v1, v2, l2, d, c);
    checks++; if (d !== exp_p) begin errors++; $display("FAIL round_pos: got=%h exp=%h", d, exp_p); end
    send_one(16'h0000, 16'hFFFE, 1'b1, v1, v2, l2, d, c);
    checks++; if (d !== exp_n) begin errors++; $display("FAIL round_neg: got=%h exp=%h", d, exp_n); end
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int recv = 0;
    logic fell = 1'b0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_d = '0;
    for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
      out_ready_i = (cyc >= 4);
      in_valid_i  = (sent < 5);
      z_i = 16'h0000; e_i = 16'(16'h0100 * (sent + 1)); in_last_i = (sent == 4);
      #1;
      if (!in_ready_o && !fell) begin
        fell = 1'b1;
        checks++; if (sent !== 2) begin errors++; $display("FAIL bp_capacity: accepts=%0d exp=2", sent); end
      end
      if (prev_stall) begin
        checks++; if (delta_o !== prev_d) begin errors++; $display("FAIL bp_stable: got=%h exp=%h", delta_o, prev_d); end
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_d = delta_o;
      if (out_valid_o && out_ready_i) begin
        checks++; if (delta_o !== 16'(16'h0040 * (recv + 1))) begin errors++; $display("FAIL bp_order: out%0d got=%h exp=%h", recv, delta_o, 16'(16'h0040 * (recv + 1))); end
        recv++;
      end
      if (in_valid_i && in_ready_o) sent++;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    checks++; if (!fell) begin errors++; $display("FAIL bp_in_ready: got=never_low exp=low"); end
    checks++; if (recv !== 5 || cnt_o !== 8'h0) begin errors++; $display("FAIL bp_count: recv=%0d cnt=%h exp=5/00", recv, cnt_o); end
    @(posedge clk_i); #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_dup: got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_counter;
    logic v1, v2, l2; logic [15:0] d; logic [7:0] c;
    for (int i = 0; i < 3; i++) begin
      send_one(16'h0000, 16'h0100, (i == 2), v1, v2, l2, d, c);
      checks++; if (c !== 8'(i) || l2 !== (i == 2)) begin errors++; $display("FAIL cnt_seq%0d: cnt=%h last=%b exp=%h/%b", i, c, l2, 8'(i), (i == 2)); end
    end
    checks++; if (cnt_o !== 8'h0) begin errors++; $display("FAIL cnt_clear: got=%h exp=00", cnt_o); end
  endtask

  task automatic test_wrap;
    int outs = 0;
    logic wrap_seen = 1'b0;
    logic [7:0] prev;
    logic v1, v2, l2; logic [15:0] d; logic [7:0] c;
    z_i = 16'h0000; e_i = 16'h0100; in_last_i = 1'b0; out_ready_i = 1'b1;
    prev = cnt_o;
    for (int cyc = 0; cyc < 310; cyc++) begin
      in_valid_i = (cyc < 300);
      #1;
      if (out_valid_o) outs++;
      @(posedge clk_i); #1;
      if (prev == 8'hFF && cnt_o == 8'h00) wrap_seen = 1'b1;
      prev = cnt_o;
    end
    checks++; if (outs !== 300) begin errors++; $display("FAIL wrap_outs: got=%0d exp=300", outs); end
    checks++; if (!wrap_seen) begin errors++; $display("FAIL wrap_seen: got=0 exp=1"); end
    checks++; if (cnt_o !== 8'd44) begin errors++; $display("FAIL wrap_cnt: got=%0d exp=44", cnt_o); end
    send_one(16'h0000, 16'h0100, 1'b1, v1, v2, l2, d, c);
    checks++; if (c !== 8'd44 || cnt_o !== 8'd0) begin errors++; $display("FAIL wrap_last: cnt=%0d after=%0d exp=44/0", c, cnt_o); end
  endtask

  task automatic test_reset_midstream;
    logic v1, v2, l2; logic [15:0] d; logic [7:0] c;
    send_one(16'h0000, 16'h0100, 1'b0, v1, v2, l2, d, c);
    checks++; if (cnt_o !== 8'd1) begin errors++; $display("FAIL mid_precnt: got=%0d exp=1", cnt_o); end
    out_ready_i = 1'b0; in_valid_i = 1'b1; z_i = 16'h0000; e_i = 16'h0100; in_last_i = 1'b0;
    @(posedge clk_i); #1;
    e_i = 16'h0200;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin errors++; $display("FAIL mid_full: valid=%b in_ready=%b exp=1/0", out_valid_o, in_ready_o); end
    rst_i = 1'b1; #1;
    checks++; if (out_valid_o !== 1'b0 || cnt_o !== 8'h0 || delta_o !== 16'h0) begin errors++; $display("FAIL mid_rst: valid=%b cnt=%h delta=%h exp=0/00/0000", out_valid_o, cnt_o, delta_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL mid_ghost: got=%b exp=0", out_valid_o); end
    send_one(16'h0000, 16'h0300, 1'b1, v1, v2, l2, d, c);
    checks++; if (v1 !== 1'b0 || v2 !== 1'b1 || d !== 16'h00C0 || c !== 8'h0) begin errors++; $display("FAIL mid_after: v1=%b v2=%b d=%h c=%h exp=0/1/00c0/00", v1, v2, d, c); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lut_range();
    test_rounding();
    test_backpressure();
    test_counter();
    test_wrap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/backprop_delta_unit.md
# backprop_delta_unit

Backpropagation delta stage that sits directly downstream of the sigmoid derivative LUT. Per element it takes the pre-activation z and the back-propagated error e, evaluates sigmoid'(z) with an internal `sigmoid_deriv` instance, and forms delta = e × sigmoid'(z) in signed fixed point. It is a two-stage, valid/ready pipelined datapath that feeds the weight-gradient systolic array, and it tracks element position within each vector.

## Interface
- DATA_WIDTH, 16, width of z, e and delta; signed two's complement, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
- FRAC_BITS, 8, fractional bits of all fixed-point values
- CNT_WIDTH, 8, width of the per-vector element counter

- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  z_i/e_i/in_last_i are valid
- in_ready_o  out  1  block accepts the input this cycle
- z_i  in  DATA_WIDTH  pre-activation value, signed
- e_i  in  DATA_WIDTH  back-propagated error, signed
- in_last_i  in  1  marks the final element of a vector
- out_valid_o  out  1  delta_o/out_last_o are valid
- out_ready_i  in  1  downstream accepts the output
- delta_o  out  DATA_WIDTH  e × sigmoid'(z), signed
- out_last_o  out  1  in_last_i delayed with its element
- cnt_o  out  CNT_WIDTH  number of outputs transferred in the current vector

## Operation
- Transfers occur when valid and ready are both high on a rising edge, on the input side and on the output side independently.
- Stage 1 (S1): on input transfer, register e_i, in_last_i and the `sigmoid_deriv` output for z_i. That output is unsigned, at most 0x0040 (0.25).
- Stage 2 (S2): register the delta from S1 into delta_o/out_last_o/out_valid_o.
- Arithmetic:
  - The product is the signed e times the zero-extended deriv, in 2·DATA_WIDTH+1 bits.
  - Without rounding, delta = product >>> FRAC_BITS (arithmetic shift, floor).
  - Because |deriv| ≤ 0.25, the result always fits in DATA_WIDTH; there is no saturation logic.
- Pipeline advance:
  - s2_adv = !out_valid_o || out_ready_i.
  - S1 moves into S2 when s2_adv. S2 loads S1's valid bit, so a bubble clears out_valid_o.
  - in_ready_o = !s1_valid || s2_adv. This is combinational from out_ready_i; no path exists from in_valid_i to in_ready_o.
- While out_valid_o && !out_ready_i, delta_o, out_last_o and cnt_o are held stable.
- Counter:
  - cnt_o increments by 1 on each output transfer with out_last_o = 0.
  - It clears to 0 on an output transfer with out_last_o = 1.
  - It wraps modulo 2^CNT_WIDTH.
- No state machine beyond the two valid bits; elements are processed independently.

## Timing
- Reset values: out_valid_o = 0, delta_o = 0, out_last_o = 0, cnt_o = 0, S1 valid = 0. in_ready_o = 1 immediately after reset.
- Latency: an element accepted at edge N shows out_valid_o = 1 after edge N+1, provided there is no stall.
- Throughput: one element per cycle when out_ready_i is held at 1.
- Simultaneous input and output transfer in the same cycle is legal. Both stages shift, with no bubble and no loss.
- Full stall: both stages valid and out_ready_i = 0 gives in_ready_o = 0. Capacity is exactly 2 elements.
- Reset asserted mid-operation drops all in-flight elements. Outputs return to reset values asynchronously, and no partial output is emitted after release.
- The `sigmoid_deriv` path is combinational and lies between z_i and S1. The multiply lies between S1 and S2.

## Configuration
- DELTA_ROUND_EN defined:
  - delta = (product + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round half up.
  - The adder is in the S1→S2 path.
- DELTA_ROUND_EN undefined: truncation by floor shift, and no rounding adder is built.

## Test plan
- Basic values, out_ready_i = 1:
  - z = 0x0000, e = 0x0100 → delta_o = 0x0040, two cycles after accept.
  - z = 0x0000, e = 0xFF00 → delta_o = 0xFFC0.
- Out of LUT range:
  - z = 0x0800, e = 0x7FFF → delta_o = 0x0000.
  - z = 0xF700, e = 0x0100 → delta_o = 0x0000.
- Rounding with z = 0:
  - e = 0x0002 → delta_o = 0x0000 without DELTA_ROUND_EN, 0x0001 with it.
  - e = 0xFFFE → delta_o = 0xFFFF without, 0x0000 with.
- Backpressure:
  - Stream 5 elements while out_ready_i is held low for 4 cycles.
  - in_ready_o falls after 2 accepts, and delta_o stays stable while stalled.
  - All 5 outputs arrive in order with no duplicates.
- Counter:
  - Send 3 elements, the last with in_last_i = 1. cnt_o reads 0, 1, 2 on successive outputs, then returns to 0.
  - Drive 300 transfers with no last: cnt_o wraps at 256.
- Reset mid-stream:
  - Assert rst_i with 2 elements in flight. out_valid_o drops immediately, and cnt_o = 0.
  - After release, the first new element appears with the correct delta and the correct latency.
